// File: rtl/fifo_unpack_if.sv
// fifo_unpack_if: word-in / sub-word-out stream bundle.
// master drives words and sinks sub-words; slave is the unpacker.
interface fifo_unpack_if #(
  parameter int IN_WIDTH = 64,
  parameter int RATIO    = 2
);
  localparam int OUT_WIDTH = IN_WIDTH / RATIO;
  localparam int IDXB      = $clog2(RATIO);

  logic [IN_WIDTH-1:0]  a_data;
  logic [IDXB-1:0]      a_offset;
  logic                 a_valid;
  logic                 a_ready;
  logic [OUT_WIDTH-1:0] b_data;
  logic                 b_valid;
  logic                 b_last;
  logic                 b_ready;

  modport master (
    output a_data, a_offset, a_valid, b_ready,
    input  a_ready, b_data, b_valid, b_last
  );

  modport slave (
    input  a_data, a_offset, a_valid, b_ready,
    output a_ready, b_data, b_valid, b_last
  );
endinterface

// File: rtl/fifo_unpack.sv
// fifo_unpack: splits one wide queue entry into RATIO sub-words,
// lowest first, with start offset and flush on redirect.
module fifo_unpack #(
  parameter int IN_WIDTH = 64,
  parameter int RATIO    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  fifo_unpack_if.slave  bus
);
  localparam int OUT_WIDTH = IN_WIDTH / RATIO;
  localparam int IDXB      = $clog2(RATIO);
  localparam logic [IDXB-1:0] LAST = IDXB'(RATIO - 1);

  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t state, state_n;
  logic [IDXB-1:0] idx, idx_n;
  logic [RATIO-1:0][OUT_WIDTH-1:0] buf_data;

  logic load;
  logic at_last;
  logic b_active;
  logic a_active;

  // Handshakes, outputs and next state; flush beats load beats drain.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    load    = 1'b0;

    at_last  = (idx == LAST);
    bus.b_valid = (state == HOLD) & ~flush;
    bus.b_data  = buf_data[idx];
    bus.b_last  = bus.b_valid & at_last;
    b_active    = bus.b_valid & bus.b_ready;
    bus.a_ready = ~flush & ((state == EMPTY) | (b_active & at_last));
    a_active    = bus.a_valid & bus.a_ready;

    if (flush) begin
      state_n = EMPTY;
      idx_n   = '0;
    end else if (a_active) begin
      state_n = HOLD;
      idx_n   = bus.a_offset;
      load    = 1'b1;
    end else if (b_active & at_last) begin
      state_n = EMPTY;
      idx_n   = '0;
    end else if (b_active) begin
      idx_n   = idx + IDXB'(1);
    end
  end

  // State and sub-word index registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      idx   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
    end
  end

  // Word buffer is only meaningful while HOLD, so it is never reset.
  always_ff @(posedge clk) begin
    if (load) buf_data <= bus.a_data;
  end
endmodule
